// File: rtl/mips_bus_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter for the single Avalon-style CPU bus.
// Registers the winning request onto the bus, waits out bus stalls and aborts via a watchdog.
module mips_bus_arbiter #(
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        grant_d,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic WDOG_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic FIXED_PRIO = (PRIORITY_MODE == 1);

    state_t            state_r, state_s;
    logic [31:0]       address_r, address_s;
    logic              read_r, read_s;
    logic              write_r, write_s;
    logic [31:0]       writedata_r, writedata_s;
    logic [3:0]        byteenable_r, byteenable_s;
    logic [31:0]       rdata_r, rdata_s;
    logic              grant_d_r, grant_d_s;
    logic              last_d_r, last_d_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              timeout_err_r, timeout_err_s;
    logic              i_req_s, d_req_s, pick_d_s, wdog_hit_s;

    // Request decode, tie-break and watchdog compare
    always_comb begin
        i_req_s    = i_read;
        d_req_s    = d_read | d_write;
        wdog_hit_s = WDOG_EN & (cnt_r == CNT_LAST);
        if (i_req_s && d_req_s) begin
            pick_d_s = FIXED_PRIO | ~last_d_r;
        end else begin
            pick_d_s = d_req_s;
        end
    end

    // Next-state and next bus-register values
    always_comb begin
        state_s       = state_r;
        address_s     = address_r;
        read_s        = read_r;
        write_s       = write_r;
        writedata_s   = writedata_r;
        byteenable_s  = byteenable_r;
        rdata_s       = rdata_r;
        grant_d_s     = grant_d_r;
        last_d_s      = last_d_r;
        cnt_s         = cnt_r;
        timeout_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_req_s || d_req_s) begin
                    grant_d_s = pick_d_s;
                    last_d_s  = pick_d_s;
                    cnt_s     = {CNT_W{1'b0}};
                    state_s   = ST_BUS;
                    if (pick_d_s) begin
                        // A simultaneous read+write from the D port is a write
                        address_s    = d_address;
                        read_s       = ~d_write;
                        write_s      = d_write;
                        writedata_s  = d_writedata;
                        byteenable_s = d_byteenable;
                    end else begin
                        address_s    = i_address;
                        read_s       = 1'b1;
                        write_s      = 1'b0;
                        byteenable_s = 4'b1111;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (!waitrequest) begin
                    if (read_r) begin
                        rdata_s = readdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    read_s  = 1'b0;
                    write_s = 1'b0;
                    state_s = ST_DONE;
                end else if (wdog_hit_s) begin
                    read_s        = 1'b0;
                    write_s       = 1'b0;
                    rdata_s       = 32'h0000_0000;
                    timeout_err_s = 1'b1;
                    state_s       = ST_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                read_s  = 1'b0;
                write_s = 1'b0;
            end
        endcase
    end

    // State and bus register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            address_r     <= 32'h0000_0000;
            read_r        <= 1'b0;
            write_r       <= 1'b0;
            writedata_r   <= 32'h0000_0000;
            byteenable_r  <= 4'b0000;
            rdata_r       <= 32'h0000_0000;
            grant_d_r     <= 1'b0;
            last_d_r      <= 1'b1;
            cnt_r         <= {CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            address_r     <= address_s;
            read_r        <= read_s;
            write_r       <= write_s;
            writedata_r   <= writedata_s;
            byteenable_r  <= byteenable_s;
            rdata_r       <= rdata_s;
            grant_d_r     <= grant_d_s;
            last_d_r      <= last_d_s;
            cnt_r         <= cnt_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    // Owner is released for exactly the one DONE cycle
    assign i_waitrequest = i_req_s & ~((state_r == ST_DONE) & ~grant_d_r);
    assign d_waitrequest = d_req_s & ~((state_r == ST_DONE) & grant_d_r);
    assign i_readdata    = rdata_r;
    assign d_readdata    = rdata_r;
    assign address       = address_r;
    assign read          = read_r;
    assign write         = write_r;
    assign writedata     = writedata_r;
    assign byteenable    = byteenable_r;
    assign grant_d       = grant_d_r;
    assign busy          = (state_r != ST_IDLE);
    assign timeout_err   = timeout_err_r;

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
Shares the single Avalon-style CPU memory bus between two requesters: instruction fetch (I port) and load/store (D port). Each port presents a standard read/write request and is stalled by its own waitrequest. The block arbitrates between ports, registers the winning request onto the bus, and tracks bus waitrequest to completion. A watchdog aborts transactions that stall too long. It sits between the CPU core and the top-level bus pins.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin between I and D; 1 = fixed priority, D always wins ties
TIMEOUT_CYCLES, 0, max cycles in BUS state before abort; 0 disables watchdog
CNT_W, 16, width of watchdog counter; TIMEOUT_CYCLES must be < 2^CNT_W

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_read  input  1  I port read request
i_address  input  32  I port byte address
i_waitrequest  output  1  I port stall
i_readdata  output  32  I port read data, valid when i_waitrequest low
d_read  input  1  D port read request
d_write  input  1  D port write request
d_address  input  32  D port byte address
d_writedata  input  32  D port write data
d_byteenable  input  4  D port byte lanes
d_waitrequest  output  1  D port stall
d_readdata  output  32  D port read data, valid when d_waitrequest low
address  output  32  bus address (registered)
read  output  1  bus read strobe (registered)
write  output  1  bus write strobe (registered)
writedata  output  32  bus write data (registered)
byteenable  output  4  bus byte enables (registered; 4'b1111 for I port)
waitrequest  input  1  bus stall
readdata  input  32  bus read data
grant_d  output  1  1 when current/last owner is D port
busy  output  1  state != IDLE
timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- States: IDLE, BUS, DONE. Reset → IDLE. Reset values: read=0, write=0, address=0, writedata=0, byteenable=0, rdata reg=0, grant_d=0, last_grant=D, counter=0, timeout_err=0.
- Port request: i_req = i_read; d_req = d_read | d_write. If d_read and d_write are both high, the transaction is a write.
- Port waitrequest (combinational): X_waitrequest = X_req & ~(state==DONE & owner==X). Waitrequest is low when there is no request.
- IDLE: if no request, stay. If exactly one port requests, grant it. On a tie: mode 1 grants D; mode 0 grants the port opposite to last_grant. On grant, register address/read/write/writedata/byteenable from the winner, set grant_d, update last_grant, clear counter, go to BUS.
- BUS: hold bus signals stable. At an edge where waitrequest==0, capture readdata into rdata (reads only; writes leave rdata unchanged), drop read/write, go to DONE. Otherwise increment counter. If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with waitrequest still high, abort: drop read/write, rdata=0, pulse timeout_err next cycle, go to DONE.
- DONE: owner's waitrequest low for exactly one cycle; X_readdata=rdata (both ports see rdata). Next state is IDLE. A request still held is treated as new and re-arbitrated.
- Minimum latency: request in cycle 0 → BUS in cycle 1 → with bus waitrequest=0, DONE in cycle 2. Three cycles per access; back-to-back accesses from one port take 3 cycles each.
- Requester signals changing or dropping while in BUS/DONE are ignored. The registered request completes and its result is discarded if no longer wanted.
- Reset mid-transaction: at the reset edge, go to IDLE and drop read/write. No completion is reported.
- Address, writedata and byteenable hold their last value in IDLE/DONE. Only read/write qualify the bus.

Test Plan:
- Single I read: i_read=1, i_address=0xBFC00000, bus waitrequest=0, readdata=0x24020005 → bus read=1 with address 0xBFC00000 in cycle 1; i_waitrequest low and i_readdata=0x24020005 in cycle 2; busy low in cycle 3.
- D write with bus stall: d_write=1, addr 0x1000, data 0xDEADBEEF, byteenable 4'b0011, waitrequest high 4 cycles → bus signals stable for 5 BUS cycles; d_waitrequest low exactly once, in the cycle after waitrequest falls.
- Tie, mode 0: i_read and d_read held continuously from reset → grants alternate I, D, I, D. Each completion is 3 cycles apart with zero-wait bus; grant_d sequence 0,1,0,1.
- Tie, mode 1: same stimulus → D granted every time; I stays stalled while D requests; I granted on the first IDLE with d_req=0.
- Watchdog, TIMEOUT_CYCLES=8: D read, waitrequest stuck high → read drops after 8 BUS cycles; timeout_err pulses once; d_readdata=0 with d_waitrequest low for 1 cycle.
- Reset mid-transaction: assert reset during BUS of a D write → after the edge, write=0, busy=0, no d_waitrequest low pulse; a subsequent I read completes normally.
